// File: rtl/sysbus.sv
// sysbus: single-master bus bridge with slave decode, timeout and interrupt controller
module sysbus #(
  parameter int          WIDTH   = 32,
  parameter int          NSLV    = 8,
  parameter int          NIRQ    = 16,
  parameter logic [31:0] IO_BASE = 32'h0000ff00,
  parameter int          TMO     = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m_req,
  input  logic                    m_wen,
  input  logic [WIDTH-1:0]        m_addr,
  input  logic [WIDTH-1:0]        m_dout,
  output logic [WIDTH-1:0]        m_din,
  output logic                    m_ack,
  output logic                    m_err,
  output logic [NSLV-1:0]         s_cs,
  output logic                    s_wen,
  output logic [3:0]              s_addr,
  output logic [WIDTH-1:0]        s_wdata,
  input  logic [NSLV*WIDTH-1:0]   s_rdata,
  input  logic [NSLV-1:0]         s_ack,
  input  logic [NIRQ-1:0]         irq_in,
  output logic                    irq_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} st_t;
  st_t               st_q, st_d;
  logic [WIDTH-1:0]  addr_q, addr_d, wdata_q, wdata_d, din_q, din_d, erraddr_q, erraddr_d;
  logic              wen_q, wen_d, ack_q, ack_d, err_q, err_d, irq_out_q;
  logic [4:0]        rg_q, rg_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NSLV-1:0]   cs_q, cs_d;
  logic [NIRQ-1:0]   pend_q, pend_d, en_q, en_d, irq_q;
  logic [WIDTH-5:0]  diff;
  logic [WIDTH-1:0]  slv_rd, int_rd;
  logic [3:0]        off;
  logic              hit, iwr, is_int;
  assign diff    = m_addr[WIDTH-1:4] - IO_BASE[WIDTH-1:4];
  assign off     = addr_q[3:0];
  assign is_int  = rg_q == 5'(NSLV);
  assign iwr     = st_q == ACCESS && is_int && wen_q;
  assign hit     = |(s_ack & cs_q);
  assign int_rd  = off == 4'd0 ? WIDTH'(pend_q) :
                   off == 4'd1 ? WIDTH'(en_q) :
                   off == 4'd2 ? WIDTH'(pend_q & en_q) :
                   off == 4'd3 ? erraddr_q : '0;
  assign pend_d  = (pend_q & ~(iwr && off == 4'd0 ? wdata_q[NIRQ-1:0] : '0)) | (irq_in & ~irq_q);
  assign en_d    = iwr && off == 4'd1 ? wdata_q[NIRQ-1:0] : en_q;
  assign m_din   = din_q;
  assign m_ack   = ack_q;
  assign m_err   = err_q;
  assign s_cs    = cs_q;
  assign s_wen   = wen_q;
  assign s_addr  = addr_q[3:0];
  assign s_wdata = wdata_q;
  assign irq_out = irq_out_q;
  // read data of the selected slave; cs_q is one-hot so OR-ing slices is a mux
  always_comb begin
    slv_rd = '0;
    for (int i = 0; i < NSLV; i++) if (cs_q[i]) slv_rd = slv_rd | s_rdata[i*WIDTH +: WIDTH];
  end
  // transfer FSM: decode, wait/timeout, one-cycle response
  always_comb begin
    st_d      = st_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    rg_d      = rg_q;
    cnt_d     = cnt_q;
    din_d     = din_q;
    erraddr_d = erraddr_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    cs_d      = '0;
    case (st_q)
      IDLE: if (m_req) begin
        addr_d  = m_addr;
        wen_d   = m_wen;
        wdata_d = m_dout;
        cnt_d   = '0;
        if (diff <= (WIDTH-4)'(NSLV)) begin
          st_d = ACCESS;
          rg_d = diff[4:0];
          cs_d = diff < (WIDTH-4)'(NSLV) ? NSLV'(1) << diff[3:0] : '0;
        end else begin
          st_d      = RESP;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          din_d     = '0;
          erraddr_d = m_addr;
        end
      end
      ACCESS: if (is_int || hit) begin
        st_d  = RESP;
        ack_d = 1'b1;
        din_d = wen_q ? '0 : is_int ? int_rd : slv_rd;
      end else if (cnt_q == 8'(TMO-1)) begin
        st_d      = RESP;
        ack_d     = 1'b1;
        err_d     = 1'b1;
        din_d     = '0;
        erraddr_d = addr_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
        cs_d  = cs_q;
      end
      default: st_d = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= IDLE;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      rg_q      <= '0;
      cnt_q     <= '0;
      din_q     <= '0;
      erraddr_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      cs_q      <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      irq_q     <= '0;
      irq_out_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      rg_q      <= rg_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      erraddr_q <= erraddr_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      cs_q      <= cs_d;
      pend_q    <= pend_d;
      en_q      <= en_d;
      irq_q     <= irq_in;
      irq_out_q <= |(pend_q & en_q);
    end
  end
endmodule

// File: tb/tb_sysbus.sv
// tb_sysbus: directed checks of decode, wait states, timeout, IRQ registers and reset
module tb_sysbus;
  logic         clk = 1'b0, reset = 1'b0;
  logic         m_req = 1'b0, m_wen = 1'b0;
  logic [31:0]  m_addr = '0, m_dout = '0, m_din;
  logic         m_ack, m_err, s_wen, irq_out;
  logic [7:0]   s_cs, s_ack = '0;
  logic [3:0]   s_addr;
  logic [31:0]  s_wdata;
  logic [255:0] s_rdata = '0;
  logic [15:0]  irq_in = '0;
  int           total = 0, bad = 0;
  logic [31:0]  rd;
  logic         er;
  int           n, acks;
  sysbus dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_dout(m_dout),
    .m_din(m_din), .m_ack(m_ack), .m_err(m_err), .s_cs(s_cs), .s_wen(s_wen), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack), .irq_in(irq_in), .irq_out(irq_out)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] r, output logic e);
    int k;
    m_req = 1'b1; m_wen = w; m_addr = a; m_dout = d;
    tick();
    m_req = 1'b0;
    k = 0;
    while (!m_ack && k < 40) begin tick(); k++; end
    chk("bus_ack", 32'(m_ack), 32'd1);
    r = m_din; e = m_err;
    tick();
  endtask
  initial begin
    tick();
    chk("rst_ack", 32'(m_ack), 0);
    chk("rst_cs", 32'(s_cs), 0);
    chk("rst_irq", 32'(irq_out), 0);
    chk("rst_din", m_din, 0);
    reset = 1'b1;
    tick();
    // zero-wait read from slave 1
    s_rdata[32 +: 32] = 32'hCAFE0001; s_ack = 8'h02;
    m_req = 1'b1; m_wen = 1'b0; m_addr = 32'hff12;
    tick();
    m_req = 1'b0;
    chk("rd_cs", 32'(s_cs), 32'h2);
    chk("rd_saddr", 32'(s_addr), 32'h2);
    chk("rd_ack_early", 32'(m_ack), 0);
    tick();
    chk("rd_ack", 32'(m_ack), 1);
    chk("rd_din", m_din, 32'hCAFE0001);
    chk("rd_err", 32'(m_err), 0);
    tick();
    chk("rd_ack_pulse", 32'(m_ack), 0);
    // write to slave 3 with four wait states
    s_ack = '0;
    m_req = 1'b1; m_wen = 1'b1; m_addr = 32'hff34; m_dout = 32'h12345678;
    tick();
    m_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      chk("wr_wen", 32'(s_wen), 1);
      chk("wr_wdata", s_wdata, 32'h12345678);
      chk("wr_cs", 32'(s_cs), 32'h8);
      acks += int'(m_ack);
      if (c == 4) s_ack = 8'h08;
      tick();
    end
    s_ack = '0;
    chk("wr_ack", 32'(m_ack), 1);
    chk("wr_err", 32'(m_err), 0);
    chk("wr_ack_during", 32'(acks), 0);
    tick();
    chk("wr_ack_pulse", 32'(m_ack), 0);
    // unmapped read
    m_req = 1'b1; m_wen = 1'b0; m_addr = 32'h10080;
    tick();
    m_req = 1'b0;
    chk("um_ack", 32'(m_ack), 1);
    chk("um_err", 32'(m_err), 1);
    chk("um_cs", 32'(s_cs), 0);
    tick();
    chk("um_ack_pulse", 32'(m_ack), 0);
    bus(1'b0, 32'hff83, 0, rd, er);
    chk("um_erraddr", rd, 32'h10080);
    chk("um_erraddr_err", 32'(er), 0);
    // stuck slave times out after TMO ACCESS cycles
    m_req = 1'b1; m_wen = 1'b0; m_addr = 32'hff50;
    s_rdata[160 +: 32] = 32'hDEADBEEF;
    tick();
    m_req = 1'b0;
    n = 0;
    while (s_cs != 0 && n < 40) begin n++; tick(); end
    chk("to_cycles", 32'(n), 15);
    chk("to_ack", 32'(m_ack), 1);
    chk("to_err", 32'(m_err), 1);
    chk("to_din", m_din, 0);
    tick();
    bus(1'b0, 32'hff83, 0, rd, er);
    chk("to_erraddr", rd, 32'hff50);
    // reserved internal offsets read zero and do not error
    bus(1'b1, 32'hff85, 32'hffffffff, rd, er);
    chk("rsv_wr_err", 32'(er), 0);
    bus(1'b0, 32'hff85, 0, rd, er);
    chk("rsv_rd", rd, 0);
    // interrupt controller
    bus(1'b1, 32'hff81, 32'h4, rd, er);
    bus(1'b0, 32'hff81, 0, rd, er);
    chk("en_rd", rd, 32'h4);
    irq_in[2] = 1'b1;
    tick();
    tick();
    chk("irq_out_set", 32'(irq_out), 1);
    bus(1'b0, 32'hff80, 0, rd, er);
    chk("pend_rd", rd, 32'h4);
    bus(1'b0, 32'hff82, 0, rd, er);
    chk("act_rd", rd, 32'h4);
    irq_in[2] = 1'b0;
    tick();
    m_req = 1'b1; m_wen = 1'b1; m_addr = 32'hff80; m_dout = 32'h4;
    tick();
    m_req = 1'b0;
    irq_in[2] = 1'b1;
    tick();
    tick();
    bus(1'b0, 32'hff80, 0, rd, er);
    chk("pend_set_wins", rd, 32'h4);
    bus(1'b1, 32'hff80, 32'h4, rd, er);
    bus(1'b0, 32'hff80, 0, rd, er);
    chk("pend_clr", rd, 0);
    chk("irq_out_clr", 32'(irq_out), 0);
    // reset mid-ACCESS
    s_ack = '0;
    m_req = 1'b1; m_wen = 1'b0; m_addr = 32'hff00;
    tick();
    m_req = 1'b0;
    chk("ra_cs_before", 32'(s_cs), 1);
    tick();
    reset = 1'b0;
    #1;
    chk("ra_cs", 32'(s_cs), 0);
    chk("ra_ack", 32'(m_ack), 0);
    tick();
    chk("ra_ack_hold", 32'(m_ack), 0);
    reset = 1'b1;
    tick();
    bus(1'b0, 32'hff81, 0, rd, er);
    chk("ra_en", rd, 0);
    chk("ra_en_err", 32'(er), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
